oven_cook_timer: RTL and testbench

//  Cook-time countdown stage downstream of the oven time-of-day clock. Holds an MM:SS
//  BCD cook time set by front-panel pulses, counts it down once per second tick,

---
 rtl/oven_cook_timer.sv | 179 +++++++++++++++++
 tb/tb_oven_cook_timer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/oven_cook_timer.sv
// oven_cook_timer: MM:SS BCD cook-time countdown with heater enable and expiry beeper.
// The cook time is set from front-panel pulses and counted down once per sec_tick.
// Optional feature macro OVEN_DELAY_START_EN adds a WAIT state. WAIT holds off the
// start until the oven clock (clk_bcd) matches delay_bcd.
module oven_cook_timer #(
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_tick,
    input  logic        btn_min,
    input  logic        btn_sec,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        delay_req,
    input  logic [15:0] clk_bcd,
    input  logic [15:0] delay_bcd,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic [2:0]  state,
    output logic        heat_on,
    output logic        beep,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [3:0] BEEP_INIT = 4'(BEEP_SECS);

    state_t      cur_state, nxt_state;
    logic [15:0] cook_time, nxt_time;   // {min_tens, min_ones, sec_tens, sec_ones}
    logic [3:0]  beep_cnt, nxt_cnt;
    logic        nxt_beep;
    logic        time_nz;

`ifndef OVEN_DELAY_START_EN
    // Delayed-start inputs have no function in this build.
    logic unused_delay;
    assign unused_delay = ^{delay_req, clk_bcd, delay_bcd};
`endif

    // +1 minute on the two minute digits, 99 wraps to 00.
    function automatic logic [7:0] inc_min(input logic [7:0] m);
        logic [3:0] tens, ones;
        tens = m[7:4];
        ones = m[3:0];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // One-second BCD decrement of MM:SS with borrow chain through all digits.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = (mt == 4'd0) ? 4'd9 : mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign time_nz = (cook_time != 16'h0000);

    // Next-state, next cook time and beeper control, one event per cycle by priority.
    always_comb begin
        nxt_state = cur_state;
        nxt_time  = cook_time;
        nxt_beep  = 1'b0;
        nxt_cnt   = 4'd0;
        case (cur_state)
            S_IDLE: begin
                if (btn_stop) begin
                    nxt_time = 16'h0000;
                end else if (btn_start && time_nz) begin
`ifdef OVEN_DELAY_START_EN
                    nxt_state = delay_req ? S_WAIT : S_RUN;
`else
                    nxt_state = S_RUN;
`endif
                end else begin
                    if (btn_min) nxt_time[15:8] = inc_min(cook_time[15:8]);
                    if (btn_sec) nxt_time[7:4] = (cook_time[7:4] == 4'd5) ? 4'd0 : cook_time[7:4] + 4'd1;
                end
            end
            S_RUN: begin
                if (btn_stop) begin
                    nxt_state = S_PAUSE;
                end else if (sec_tick) begin
                    nxt_time = dec_time(cook_time);
                    if (nxt_time == 16'h0000) begin
                        nxt_state = S_DONE;
                        nxt_beep  = 1'b1;
                        nxt_cnt   = BEEP_INIT;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_stop) begin
                    nxt_state = S_IDLE;
                    nxt_time  = 16'h0000;
                end else if (btn_start) begin
                    nxt_state = S_RUN;
                end
            end
            S_DONE: begin
                nxt_time = 16'h0000;
                nxt_beep = beep;
                nxt_cnt  = beep_cnt;
                if (btn_stop || btn_start || btn_min || btn_sec) begin
                    nxt_state = S_IDLE;
                    nxt_beep  = 1'b0;
                    nxt_cnt   = 4'd0;
                end else if (sec_tick && beep_cnt != 4'd0) begin
                    nxt_cnt = beep_cnt - 4'd1;
                    if (beep_cnt == 4'd1) nxt_beep = 1'b0;
                end
            end
`ifdef OVEN_DELAY_START_EN
            S_WAIT: begin
                if (btn_stop) begin
                    nxt_state = S_IDLE;
                    nxt_time  = 16'h0000;
                end else if (clk_bcd == delay_bcd) begin
                    nxt_state = S_RUN;
                end
            end
`endif
            default: nxt_state = S_IDLE;
        endcase
    end

    // State, cook time and all outputs registered; async reset returns everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            cook_time <= 16'h0000;
            beep_cnt  <= 4'd0;
            beep      <= 1'b0;
            heat_on   <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cook_time <= nxt_time;
            beep_cnt  <= nxt_cnt;
            beep      <= nxt_beep;
            heat_on   <= (nxt_state == S_RUN);
            done      <= (nxt_state == S_DONE);
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = cook_time;
    assign state = cur_state;

endmodule

// File: tb/tb_oven_cook_timer.sv
// Directed testbench for oven_cook_timer with hand-computed expected values.
module tb_oven_cook_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sec_tick = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
    logic        btn_start = 1'b0, btn_stop = 1'b0, delay_req = 1'b0;
    logic [15:0] clk_bcd = 16'h0000, delay_bcd = 16'h0000;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0]  state;
    logic        heat_on, beep, done;

    int vectors = 0;
    int miscompares = 0;

    oven_cook_timer #(.BEEP_SECS(3)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
        .btn_min(btn_min), .btn_sec(btn_sec), .btn_start(btn_start), .btn_stop(btn_stop),
        .delay_req(delay_req), .clk_bcd(clk_bcd), .delay_bcd(delay_bcd),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .state(state), .heat_on(heat_on), .beep(beep), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic m, input logic s, input logic st, input logic sp, input logic tk);
        btn_min = m; btn_sec = s; btn_start = st; btn_stop = sp; sec_tick = tk;
        @(posedge clk);
        #1;
        btn_min = 0; btn_sec = 0; btn_start = 0; btn_stop = 0; sec_tick = 0;
    endtask

    function automatic logic [15:0] tm();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] ctl();
        return {10'b0, state, heat_on, beep, done};
    endfunction

    initial begin
        // Reset values
        #12;
        chk("reset_time", tm(), 16'h0000);
        chk("reset_ctl", ctl(), 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Setting in IDLE
        step(1,0,0,0,0); step(1,0,0,0,0);
        step(0,1,0,0,0); step(0,1,0,0,0); step(0,1,0,0,0);
        chk("set_0230", tm(), 16'h0230);
        chk("set_idle_ctl", ctl(), 16'h0000);
        for (int i = 0; i < 98; i++) step(1,0,0,0,0);
        chk("min_wrap_0030", tm(), 16'h0030);
        step(0,1,0,0,0); step(0,1,0,0,0); step(0,1,0,0,0);
        chk("sec_wrap_0000", tm(), 16'h0000);

        // Countdown to expiry
        step(1,0,0,0,0);
        step(0,0,1,0,0);
        chk("run_ctl", ctl(), {10'b0, 3'd1, 1'b1, 1'b0, 1'b0});
        step(0,0,0,0,1);
        chk("run_0059", tm(), 16'h0059);
        for (int i = 0; i < 58; i++) step(0,0,0,0,1);
        chk("run_0001", tm(), 16'h0001);
        step(0,0,0,0,1);
        chk("expire_time", tm(), 16'h0000);
        chk("expire_ctl", ctl(), {10'b0, 3'd3, 1'b0, 1'b1, 1'b1});

        // Beeper duration and exit from DONE
        step(0,0,0,0,1); step(0,0,0,0,1);
        chk("beep_still_on", ctl(), {10'b0, 3'd3, 1'b0, 1'b1, 1'b1});
        step(0,0,0,0,1);
        chk("beep_off", ctl(), {10'b0, 3'd3, 1'b0, 1'b0, 1'b1});
        step(1,0,0,0,0);
        chk("done_exit_ctl", ctl(), 16'h0000);
        chk("done_exit_time", tm(), 16'h0000);

        // Pause / resume / cancel
        step(0,1,0,0,0);
        step(0,0,1,0,0);
        step(1,0,0,0,0);
        chk("run_ignores_min", tm(), 16'h0010);
        step(0,0,0,1,1);
        chk("pause_time", tm(), 16'h0010);
        chk("pause_ctl", ctl(), {10'b0, 3'd2, 1'b0, 1'b0, 1'b0});
        step(0,0,0,0,1);
        chk("pause_ignores_tick", tm(), 16'h0010);
        step(0,0,1,0,0);
        chk("resume_ctl", ctl(), {10'b0, 3'd1, 1'b1, 1'b0, 1'b0});
        step(0,0,0,1,0); step(0,0,0,1,0);
        chk("cancel_ctl", ctl(), 16'h0000);
        chk("cancel_time", tm(), 16'h0000);

        // Start at zero, simultaneous set, priority, borrow across tens of minutes
        step(0,0,1,0,0);
        chk("start_zero_ignored", ctl(), 16'h0000);
        step(1,1,0,0,0);
        chk("min_sec_same_cycle", tm(), 16'h0110);
        step(0,0,0,1,0);
        for (int i = 0; i < 10; i++) step(1,0,0,0,0);
        chk("set_1000", tm(), 16'h1000);
        step(0,0,1,0,0);
        step(0,0,0,0,1);
        chk("borrow_0959", tm(), 16'h0959);
        step(0,0,0,1,0); step(0,0,0,1,0);
        step(0,1,0,0,0);
        step(1,0,1,0,0);
        chk("start_beats_min_time", tm(), 16'h0010);
        chk("start_beats_min_ctl", ctl(), {10'b0, 3'd1, 1'b1, 1'b0, 1'b0});
        step(0,0,0,0,1);
        chk("run_0009", tm(), 16'h0009);

        // Asynchronous reset mid-RUN
        rst_n = 1'b0;
        #2;
        chk("async_reset_time", tm(), 16'h0000);
        chk("async_reset_ctl", ctl(), 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef OVEN_DELAY_START_EN
        // Delayed start
        step(1,0,0,0,0);
        delay_bcd = 16'h0712; clk_bcd = 16'h0711; delay_req = 1'b1;
        step(0,0,1,0,0);
        chk("wait_ctl", ctl(), {10'b0, 3'd4, 1'b0, 1'b0, 1'b0});
        step(0,0,0,0,1);
        chk("wait_hold_time", tm(), 16'h0100);
        clk_bcd = 16'h0712;
        step(0,0,0,0,0);
        chk("wait_to_run", ctl(), {10'b0, 3'd1, 1'b1, 1'b0, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
